// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch stage.
//   fetch_state_e : fetch controller states (IDLE, REQ, WAIT, DRAIN)
//   NOP_INSTR     : canonical RISC-V NOP (addi x0, x0, 0) shown to decode
//                   whenever no valid instruction is presented
//   PC_STEP       : sequential PC increment (one 32-bit instruction word)
// -----------------------------------------------------------------------------
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      WAIT  = 2'd2,
      DRAIN = 2'd3
   } fetch_state_e;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   localparam logic [31:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/fetch_skid_buffer.sv
// -----------------------------------------------------------------------------
// fetch_skid_buffer
// One-entry holding register for a fetched {instr, pc} pair that arrived while
// decode was stalled.
//   clk, rst  : clock, asynchronous active-high reset (clears the full flag)
//   push_i    : capture instr_i/pc_i
//   pop_i     : release the held entry
//   flush_i   : discard the held entry (wins over push/pop)
//   instr_i   : instruction to capture
//   pc_i      : PC of instr_i
//   full_o    : an entry is held
//   instr_o   : held instruction
//   pc_o      : PC of held instruction
// -----------------------------------------------------------------------------
module fetch_skid_buffer
   import fetch_pkg::*;
#(
   parameter int unsigned Width = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic             flush_i,
   input  logic [Width-1:0] instr_i,
   input  logic [Width-1:0] pc_i,
   output logic             full_o,
   output logic [Width-1:0] instr_o,
   output logic [Width-1:0] pc_o
);

   logic             full_q, full_d;
   logic [Width-1:0] instr_q;
   logic [Width-1:0] pc_q;

   always_comb begin
      full_d = full_q;
      if (flush_i) begin
         full_d = 1'b0;
      end else if (push_i) begin
         full_d = 1'b1;
      end else if (pop_i) begin
         full_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full_q <= 1'b0;
      end else begin
         full_q <= full_d;
      end
   end

   // Payload is qualified by full_q, so it needs no reset.
   always_ff @(posedge clk) begin
      if (push_i && !flush_i) begin
         instr_q <= instr_i;
         pc_q    <= pc_i;
      end
   end

   assign full_o  = full_q;
   assign instr_o = instr_q;
   assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction fetch stage: holds the PC, issues one word request at a time to
// instruction memory and presents fetched instructions to decode. A one-entry
// skid buffer absorbs a response that arrives while decode is stalled.
// Redirect target = redirect_base + ImmOp (bit 0 cleared for JALR).
//
// Optional feature macro: FETCH_MISALIGN_TRAP_EN
//   defined   : a redirect target with bit 1 set raises a sticky
//               fetch_misaligned and parks the stage in IDLE until the next
//               redirect (which clears the flag).
//   undefined : target bits [1:0] are forced to zero, fetch_misaligned = 0.
//
// Ports:
//   clk, rst        : clock (rising edge), asynchronous active-high reset
//   imem_req/addr   : request valid / word address
//   imem_ack        : request accepted this cycle
//   imem_rvalid/rdata: response valid / instruction word
//   redirect_valid  : one-cycle redirect pulse from execute
//   redirect_base   : branch/JAL PC or rs1 for JALR
//   ImmOp           : sign-extended immediate of the redirecting instruction
//   redirect_jalr   : clear bit 0 of the target
//   stall_d         : decode cannot accept this cycle
//   instr_d/pc_d/pc_plus4_d/valid_d : instruction presented to decode
//   fetch_misaligned: misaligned redirect flag
// -----------------------------------------------------------------------------
module fetch_stage
   import fetch_pkg::*;
#(
   parameter int unsigned      Width    = 32,
   parameter logic [Width-1:0] RESET_PC = '0
) (
   input  logic             clk,
   input  logic             rst,
   output logic             imem_req,
   output logic [Width-1:0] imem_addr,
   input  logic             imem_ack,
   input  logic             imem_rvalid,
   input  logic [Width-1:0] imem_rdata,
   input  logic             redirect_valid,
   input  logic [Width-1:0] redirect_base,
   input  logic [Width-1:0] ImmOp,
   input  logic             redirect_jalr,
   input  logic             stall_d,
   output logic [Width-1:0] instr_d,
   output logic [Width-1:0] pc_d,
   output logic [Width-1:0] pc_plus4_d,
   output logic             valid_d,
   output logic             fetch_misaligned
);

   localparam logic [Width-1:0] NOP  = Width'(NOP_INSTR);
   localparam logic [Width-1:0] STEP = Width'(PC_STEP);

   fetch_state_e     state_q, state_d;
   logic [Width-1:0] fpc_q, fpc_d;
   logic [Width-1:0] req_pc_q, req_pc_d;
   logic [Width-1:0] out_instr_q, out_instr_d;
   logic [Width-1:0] out_pc_q, out_pc_d;
   logic [Width-1:0] out_pc4_q, out_pc4_d;
   logic             out_vld_q, out_vld_d;

   logic             accept;
   logic             resp_live;
   logic [Width-1:0] target_raw;
   logic [Width-1:0] target;
   logic             trap_redirect;
   logic             trapped;

   logic             skid_push, skid_pop, skid_full;
   logic [Width-1:0] skid_instr, skid_pc;

   // Sum wraps modulo 2^Width; JALR clears bit 0 before alignment is judged.
   assign target_raw = (redirect_base + ImmOp) & ~{{(Width-1){1'b0}}, redirect_jalr};
   assign target     = target_raw & ~Width'(3);

`ifdef FETCH_MISALIGN_TRAP_EN
   logic misalign_q, misalign_d;

   assign trap_redirect = redirect_valid & target_raw[1];
   assign trapped       = misalign_q;

   // Every redirect re-evaluates the flag, so a good target clears it.
   always_comb begin
      misalign_d = misalign_q;
      if (redirect_valid) begin
         misalign_d = target_raw[1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         misalign_q <= 1'b0;
      end else begin
         misalign_q <= misalign_d;
      end
   end

   assign fetch_misaligned = misalign_q;
`else
   assign trap_redirect    = 1'b0;
   assign trapped          = 1'b0;
   assign fetch_misaligned = 1'b0;
`endif

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      if (redirect_valid) begin
         if (trap_redirect) begin
            state_d = IDLE;
         end else begin
            case (state_q)
               IDLE:    state_d = REQ;
               // An accepted request at the old PC is now stale.
               REQ:     state_d = accept ? DRAIN : REQ;
               WAIT:    state_d = imem_rvalid ? REQ : DRAIN;
               DRAIN:   state_d = imem_rvalid ? REQ : DRAIN;
               default: state_d = IDLE;
            endcase
         end
      end else begin
         case (state_q)
            IDLE:    state_d = trapped ? IDLE : REQ;
            REQ:     state_d = accept ? WAIT : REQ;
            WAIT:    state_d = imem_rvalid ? REQ : WAIT;
            DRAIN:   state_d = imem_rvalid ? REQ : DRAIN;
            default: state_d = IDLE;
         endcase
      end
   end

   // ---------------- FSM: outputs ----------------
   // No new request while the skid entry is still waiting for decode.
   always_comb begin
      imem_req = (state_q == REQ) && !skid_full;
   end

   assign imem_addr = fpc_q;
   assign accept    = imem_req & imem_ack;
   assign resp_live = (state_q == WAIT) && imem_rvalid;

   // ---------------- PC and decode output register ----------------
   always_comb begin
      fpc_d       = fpc_q;
      req_pc_d    = req_pc_q;
      out_instr_d = out_instr_q;
      out_pc_d    = out_pc_q;
      out_pc4_d   = out_pc4_q;
      out_vld_d   = out_vld_q;
      skid_push   = 1'b0;
      skid_pop    = 1'b0;

      if (redirect_valid) begin
         fpc_d = target;
      end else if (accept) begin
         fpc_d = fpc_q + STEP;
      end
      if (accept) begin
         req_pc_d = fpc_q;
      end

      if (redirect_valid) begin
         out_vld_d   = 1'b0;
         out_instr_d = NOP;
      end else if (out_vld_q && stall_d) begin
         if (resp_live) begin
            skid_push = 1'b1;
         end
      end else if (skid_full) begin
         // A full skid implies no request is outstanding, so no live response
         // can collide with this load.
         skid_pop    = 1'b1;
         out_vld_d   = 1'b1;
         out_instr_d = skid_instr;
         out_pc_d    = skid_pc;
         out_pc4_d   = skid_pc + STEP;
      end else if (resp_live) begin
         out_vld_d   = 1'b1;
         out_instr_d = imem_rdata;
         out_pc_d    = req_pc_q;
         out_pc4_d   = req_pc_q + STEP;
      end else begin
         out_vld_d   = 1'b0;
         out_instr_d = NOP;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fpc_q       <= RESET_PC;
         out_instr_q <= NOP;
         out_pc_q    <= '0;
         out_pc4_q   <= '0;
         out_vld_q   <= 1'b0;
      end else begin
         fpc_q       <= fpc_d;
         out_instr_q <= out_instr_d;
         out_pc_q    <= out_pc_d;
         out_pc4_q   <= out_pc4_d;
         out_vld_q   <= out_vld_d;
      end
   end

   // PC of the outstanding request; only read while a response is expected.
   always_ff @(posedge clk) begin
      req_pc_q <= req_pc_d;
   end

   fetch_skid_buffer #(
      .Width (Width)
   ) u_skid (
      .clk     (clk),
      .rst     (rst),
      .push_i  (skid_push),
      .pop_i   (skid_pop),
      .flush_i (redirect_valid),
      .instr_i (imem_rdata),
      .pc_i    (req_pc_q),
      .full_o  (skid_full),
      .instr_o (skid_instr),
      .pc_o    (skid_pc)
   );

   assign instr_d    = out_instr_q;
   assign pc_d       = out_pc_q;
   assign pc_plus4_d = out_pc4_q;
   assign valid_d    = out_vld_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_base;
   logic [31:0] ImmOp;
   logic        redirect_jalr;
   logic        stall_d;
   logic [31:0] instr_d;
   logic [31:0] pc_d;
   logic [31:0] pc_plus4_d;
   logic        valid_d;
   logic        fetch_misaligned;

   fetch_stage #(
      .Width    (32),
      .RESET_PC (32'h0000_0100)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .imem_req         (imem_req),
      .imem_addr        (imem_addr),
      .imem_ack         (imem_ack),
      .imem_rvalid      (imem_rvalid),
      .imem_rdata       (imem_rdata),
      .redirect_valid   (redirect_valid),
      .redirect_base    (redirect_base),
      .ImmOp            (ImmOp),
      .redirect_jalr    (redirect_jalr),
      .stall_d          (stall_d),
      .instr_d          (instr_d),
      .pc_d             (pc_d),
      .pc_plus4_d       (pc_plus4_d),
      .valid_d          (valid_d),
      .fetch_misaligned (fetch_misaligned)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] base;
      logic [31:0] imm;
      logic        jalr;
      logic [31:0] exp_addr;
      logic [31:0] exp_next;
   } vec_t;

   vec_t        vecs[$];
   logic [31:0] aq[$];   // expected accepted request addresses
   logic [31:0] dq[$];   // expected PCs handed to decode

   int          n_chk = 0;
   int          n_err = 0;
   int          n_acc = 0;
   int          lat = 1;
   logic        pend = 1'b0;
   int          pend_cnt = 0;
   logic [31:0] pend_addr = '0;

   function automatic logic [31:0] mk(input logic [31:0] a);
      return a ^ 32'h1357_9BD0;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // One clock cycle: score the current cycle, take the edge, then play memory.
   task automatic step();
      logic        acc;
      logic [31:0] a;
      logic [31:0] e;
      acc = imem_req && imem_ack;
      a   = imem_addr;
      if (imem_req) chk("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
      if (acc) begin
         n_acc++;
         if (aq.size() > 0) begin
            e = aq.pop_front();
            chk("req_addr", a, e);
         end
      end
      if (valid_d && !stall_d && !redirect_valid && dq.size() > 0) begin
         e = dq.pop_front();
         chk("deliv_pc", pc_d, e);
         chk("deliv_pc4", pc_plus4_d, e + 32'd4);
         chk("deliv_instr", instr_d, mk(e));
      end
      @(posedge clk);
      #1;
      redirect_valid = 1'b0;
      imem_rvalid    = 1'b0;
      if (acc) begin
         pend      = 1'b1;
         pend_cnt  = lat;
         pend_addr = a;
      end
      if (pend) begin
         pend_cnt--;
         if (pend_cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mk(pend_addr);
            pend        = 1'b0;
         end
      end
   endtask

   task automatic do_reset();
      rst            = 1'b1;
      stall_d        = 1'b0;
      redirect_valid = 1'b0;
      redirect_base  = '0;
      ImmOp          = '0;
      redirect_jalr  = 1'b0;
      imem_ack       = 1'b1;
      imem_rvalid    = 1'b0;
      imem_rdata     = '0;
      pend           = 1'b0;
      lat            = 1;
      n_acc          = 0;
      aq.delete();
      dq.delete();
      @(posedge clk);
      #1;
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_valid", {31'd0, valid_d}, 32'd0);
      chk("rst_instr", instr_d, 32'h0000_0013);
      chk("rst_pc", pc_d, 32'd0);
      chk("rst_pc4", pc_plus4_d, 32'd0);
      chk("rst_mis", {31'd0, fetch_misaligned}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic end_seq(input string nm);
      chk({nm, "_addr_left"}, aq.size(), 32'd0);
      chk({nm, "_deliv_left"}, dq.size(), 32'd0);
   endtask

   task automatic redirect(input logic [31:0] b, input logic [31:0] i, input logic j);
      redirect_valid = 1'b1;
      redirect_base  = b;
      ImmOp          = i;
      redirect_jalr  = j;
   endtask

   initial begin
      vecs.push_back('{base: 32'h0000_0200, imm: 32'hFFFF_FFF0, jalr: 1'b0, exp_addr: 32'h0000_01F0, exp_next: 32'h0000_01F4});
      vecs.push_back('{base: 32'h0000_0301, imm: 32'h0000_0000, jalr: 1'b1, exp_addr: 32'h0000_0300, exp_next: 32'h0000_0304});
      vecs.push_back('{base: 32'hFFFF_FFF0, imm: 32'h0000_000C, jalr: 1'b0, exp_addr: 32'hFFFF_FFFC, exp_next: 32'h0000_0000});
      vecs.push_back('{base: 32'h0000_1000, imm: 32'h0000_07FC, jalr: 1'b0, exp_addr: 32'h0000_17FC, exp_next: 32'h0000_1800});
      vecs.push_back('{base: 32'h8000_0000, imm: 32'h8000_0000, jalr: 1'b0, exp_addr: 32'h0000_0000, exp_next: 32'h0000_0004});
`ifndef FETCH_MISALIGN_TRAP_EN
      vecs.push_back('{base: 32'h0000_0302, imm: 32'h0000_0000, jalr: 1'b0, exp_addr: 32'h0000_0300, exp_next: 32'h0000_0304});
`endif

      // Sequential fetch from RESET_PC, one instruction per two cycles.
      do_reset();
      aq = '{32'h100, 32'h104, 32'h108, 32'h10C};
      dq = '{32'h100, 32'h104, 32'h108};
      chk("idle_no_req", {31'd0, imem_req}, 32'd0);
      for (int c = 0; c < 8; c++) begin
         if (c == 4) chk("valid_pulse_low", {31'd0, valid_d}, 32'd0);
         step();
      end
      chk("seq_accepts", n_acc, 32'd4);
      end_seq("seq");

      // Decode stall with a response landing in the skid buffer.
      do_reset();
      aq = '{32'h100, 32'h104, 32'h108, 32'h10C};
      dq = '{32'h100, 32'h104, 32'h108};
      for (int c = 0; c < 11; c++) begin
         stall_d = (c >= 3 && c <= 6);
         if (c == 5 || c == 6) chk("stall_no_req", {31'd0, imem_req}, 32'd0);
         if (c == 6) begin
            chk("stall_hold_vld", {31'd0, valid_d}, 32'd1);
            chk("stall_hold_pc", pc_d, 32'h100);
            chk("stall_hold_instr", instr_d, mk(32'h100));
         end
         step();
      end
      stall_d = 1'b0;
      end_seq("stall");

      // Redirect while waiting on a slow response: stale data is drained.
      do_reset();
      aq = '{32'h100, 32'h104, 32'h1F0};
      dq = '{32'h1F0};
      for (int c = 0; c < 10; c++) begin
         if (c == 3) lat = 3;
         if (c == 5) lat = 1;
         stall_d = (c == 3 || c == 4);
         if (c == 4) begin
            chk("wait_vld_before", {31'd0, valid_d}, 32'd1);
            redirect(32'h200, 32'hFFFF_FFF0, 1'b0);
         end
         if (c == 5) chk("wait_vld_dropped", {31'd0, valid_d}, 32'd0);
         if (c == 5 || c == 6) chk("drain_no_req", {31'd0, imem_req}, 32'd0);
         if (c == 7) begin
            chk("stale_discarded", {31'd0, valid_d}, 32'd0);
            chk("drain_next_req", {31'd0, imem_req}, 32'd1);
            chk("drain_next_addr", imem_addr, 32'h1F0);
         end
         step();
      end
      stall_d = 1'b0;
      end_seq("drain");

      // Redirect coinciding with rvalid: straight back to REQ at the target.
      do_reset();
      aq = '{32'h100, 32'h410};
      dq = '{32'h410};
      for (int c = 0; c < 6; c++) begin
         if (c == 2) redirect(32'h400, 32'h10, 1'b0);
         if (c == 3) begin
            chk("rv_redir_req", {31'd0, imem_req}, 32'd1);
            chk("rv_redir_addr", imem_addr, 32'h410);
            chk("rv_redir_vld", {31'd0, valid_d}, 32'd0);
         end
         step();
      end
      end_seq("rvredir");

      // Table of redirect targets, taken in REQ without an ack.
      for (int v = 0; v < vecs.size(); v++) begin
         do_reset();
         aq.push_back(vecs[v].exp_addr);
         aq.push_back(vecs[v].exp_next);
         dq.push_back(vecs[v].exp_addr);
         step();
         imem_ack = 1'b0;
         redirect(vecs[v].base, vecs[v].imm, vecs[v].jalr);
         step();
         imem_ack = 1'b1;
         chk("vec_req", {31'd0, imem_req}, 32'd1);
         chk("vec_addr", imem_addr, vecs[v].exp_addr);
         step();
         step();
         chk("vec_vld", {31'd0, valid_d}, 32'd1);
         chk("vec_pc", pc_d, vecs[v].exp_addr);
         chk("vec_pc4", pc_plus4_d, vecs[v].exp_addr + 32'd4);
         chk("vec_next_addr", imem_addr, vecs[v].exp_next);
         chk("vec_mis", {31'd0, fetch_misaligned}, 32'd0);
         step();
         end_seq("vec");
      end

`ifdef FETCH_MISALIGN_TRAP_EN
      // Misaligned target parks the stage until a good redirect.
      do_reset();
      step();
      imem_ack = 1'b0;
      redirect(32'h302, 32'h0, 1'b0);
      step();
      imem_ack = 1'b1;
      for (int c = 0; c < 4; c++) begin
         chk("trap_flag", {31'd0, fetch_misaligned}, 32'd1);
         chk("trap_no_req", {31'd0, imem_req}, 32'd0);
         step();
      end
      chk("trap_accepts", n_acc, 32'd0);
      redirect(32'h400, 32'h0, 1'b0);
      step();
      chk("trap_clear", {31'd0, fetch_misaligned}, 32'd0);
      chk("trap_resume_req", {31'd0, imem_req}, 32'd1);
      chk("trap_resume_addr", imem_addr, 32'h400);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
